// File: rtl/spi_flash_reader_if.sv
// Processor memory read bus between the core and the SPI flash reader.
// master: drives mem_addr/mem_rstrb; slave: returns mem_rdata/mem_rbusy.
interface spi_flash_reader_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;

  modport master (
    output mem_addr,
    output mem_rstrb,
    input  mem_rdata,
    input  mem_rbusy
  );

  modport slave (
    input  mem_addr,
    input  mem_rstrb,
    output mem_rdata,
    output mem_rbusy
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Word reads from SPI NOR flash (READ 0x03 + 24-bit address, 32 data bits).
// Ports: clk, resetn, bus (mem read slave), spi_cs_n/spi_clk/spi_mosi out, spi_miso in.
module spi_flash_reader #(
  parameter int          CLK_DIV      = 1,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000
) (
  input  logic               clk,
  input  logic               resetn,
  spi_flash_reader_if.slave  bus,
  output logic               spi_cs_n,
  output logic               spi_clk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;

  logic [23:0] flash_addr;
  logic        half_done;
  logic        unused_addr;

  // Word aligned; the sum wraps inside the 24-bit flash space.
  assign flash_addr  = {bus.mem_addr[23:2], 2'b00} + FLASH_OFFSET;
  assign half_done   = (div_q == DIV_LAST);
  assign unused_addr = ^{bus.mem_addr[31:24], bus.mem_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bit_q   <= '0;
      div_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_rstrb) begin
          state_d = SEND;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          bit_d   = '0;
          div_d   = '0;
          tx_d    = {8'h03, flash_addr};
          mosi_d  = tx_d[31];
        end
      end
      SEND, RECV: begin
        if (!half_done) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture flash data, MSB first.
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = IDLE;
              cs_n_d  = 1'b1;
              busy_d  = 1'b0;
              mosi_d  = 1'b0;
              bit_d   = '0;
              // Flash streams B0..B3; the bus word is little-endian.
              rdata_d = {rx_q[7:0], rx_q[15:8],
                         rx_q[23:16], rx_q[31:24]};
            end else begin
              bit_d = bit_q + 6'd1;
              tx_d  = {tx_q[30:0], 1'b0};
              // Next command bit while sending; idle low while receiving.
              mosi_d = (bit_q < 6'd31) ? tx_q[30] : 1'b0;
              if (bit_q == 6'd31) begin
                state_d = RECV;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rbusy = busy_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (div/offset variants) share one flash model.
// Scoreboard queues hold expected command, data and busy length per read.
module tb_spi_flash_reader;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        rstrb;
  logic [1:0]  sel;
  logic        rnd_en;
  logic        rnd_bit;
  logic        model_miso;
  logic        miso;

  logic [2:0]  cs_v, sclk_v, mosi_v, busy_v;
  logic [31:0] rdata_v [3];
  logic        cs_m, sclk_m, mosi_m, busy_m;
  logic [31:0] rdata_m;

  int n_chk;
  int n_fail;

  spi_flash_reader_if bus0 ();
  spi_flash_reader_if bus1 ();
  spi_flash_reader_if bus2 ();

  assign bus0.mem_addr  = addr;
  assign bus1.mem_addr  = addr;
  assign bus2.mem_addr  = addr;
  assign bus0.mem_rstrb = rstrb & (sel == 2'd0);
  assign bus1.mem_rstrb = rstrb & (sel == 2'd1);
  assign bus2.mem_rstrb = rstrb & (sel == 2'd2);
  assign rdata_v[0] = bus0.mem_rdata;
  assign rdata_v[1] = bus1.mem_rdata;
  assign rdata_v[2] = bus2.mem_rdata;
  assign busy_v = {bus2.mem_rbusy, bus1.mem_rbusy, bus0.mem_rbusy};

  assign miso    = rnd_en ? rnd_bit : model_miso;
  assign cs_m    = cs_v[sel];
  assign sclk_m  = sclk_v[sel];
  assign mosi_m  = mosi_v[sel];
  assign busy_m  = busy_v[sel];
  assign rdata_m = rdata_v[sel];

  spi_flash_reader #(.CLK_DIV(1), .FLASH_OFFSET(24'h000000)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0),
    .spi_cs_n(cs_v[0]), .spi_clk(sclk_v[0]),
    .spi_mosi(mosi_v[0]), .spi_miso(miso)
  );

  spi_flash_reader #(.CLK_DIV(1), .FLASH_OFFSET(24'h100000)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1),
    .spi_cs_n(cs_v[1]), .spi_clk(sclk_v[1]),
    .spi_mosi(mosi_v[1]), .spi_miso(miso)
  );

  spi_flash_reader #(.CLK_DIV(3)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2),
    .spi_cs_n(cs_v[2]), .spi_clk(sclk_v[2]),
    .spi_mosi(mosi_v[2]), .spi_miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model: captures 32 command bits, then streams rsp MSB first.
  logic [31:0] rsp;
  logic [31:0] cmd_cap;
  logic        mosi_recv_seen;
  int          bitn;
  int          n_cs_fall;
  int          n_done;
  int          n_sclk_edges;
  time         t_cs_fall, t_rise0, t_rise1;

  initial begin
    bitn = 0; n_cs_fall = 0; n_done = 0; n_sclk_edges = 0;
    model_miso = 1'b0; cmd_cap = '0; mosi_recv_seen = 1'b0;
  end

  always @(negedge cs_m) begin
    bitn = 0;
    cmd_cap = '0;
    mosi_recv_seen = 1'b0;
    model_miso = 1'b0;
    t_cs_fall = $time;
    n_cs_fall++;
  end

  always @(posedge sclk_m) begin
    if (cs_m === 1'b0) begin
      if (bitn < 32) cmd_cap = {cmd_cap[30:0], mosi_m};
      else if (mosi_m !== 1'b0) mosi_recv_seen = 1'b1;
      if (bitn == 0) t_rise0 = $time;
      if (bitn == 1) t_rise1 = $time;
      bitn++;
    end
  end

  always @(negedge sclk_m) begin
    if (cs_m === 1'b0 && bitn >= 32 && bitn < 64)
      model_miso = rsp[63 - bitn];
  end

  always @(sclk_m) n_sclk_edges++;
  always @(negedge busy_m) n_done++;

  logic [31:0] exp_cmd_q [$];
  logic [31:0] exp_dat_q [$];
  int          exp_lat_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] ecmd, input logic [31:0] edat,
                          input int elat);
    exp_cmd_q.push_back(ecmd);
    exp_dat_q.push_back(edat);
    exp_lat_q.push_back(elat);
  endtask

  task automatic start_read(input logic [31:0] a, input logic [31:0] r,
                            input logic [31:0] ecmd, input logic [31:0] edat,
                            input int elat);
    @(negedge clk);
    addr = a;
    rsp = r;
    rstrb = 1'b1;
    push_exp(ecmd, edat, elat);
    @(negedge clk);
    rstrb = 1'b0;
    chk("busy_rise", 32'(busy_m), 32'd1);
  endtask

  // Counts busy cycles; optionally strobes at flash bits pa/pb or on the
  // last busy cycle (early), then scores the completed read.
  task automatic wait_done(input string tag, input int pa, input int pb,
                           input bit early, input logic [31:0] alt_addr);
    int cnt = 0;
    int elat;
    bit pa_d = 0;
    bit pb_d = 0;
    bit rd_chg = 0;
    logic [31:0] rd0;
    logic [31:0] ecmd;
    logic [31:0] edat;
    elat = exp_lat_q[0];
    rd0 = rdata_m;
    while (busy_m === 1'b1 && cnt < 4000) begin
      rstrb = 1'b0;
      cnt++;
      if (rdata_m !== rd0) rd_chg = 1'b1;
      if (!pa_d && bitn == pa) begin rstrb = 1'b1; addr = alt_addr; pa_d = 1'b1; end
      if (!pb_d && bitn == pb) begin rstrb = 1'b1; addr = alt_addr; pb_d = 1'b1; end
      if (early && cnt == elat) rstrb = 1'b1;
      @(negedge clk);
    end
    ecmd = exp_cmd_q.pop_front();
    edat = exp_dat_q.pop_front();
    void'(exp_lat_q.pop_front());
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(elat));
    chk({tag, "_cmd"}, cmd_cap, ecmd);
    chk({tag, "_rdata"}, rdata_m, edat);
    chk({tag, "_rdata_stable"}, 32'(rd_chg), 32'd0);
    chk({tag, "_mosi_recv_low"}, 32'(mosi_recv_seen), 32'd0);
    chk({tag, "_cs_high"}, 32'(cs_m), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0, dn0, k;
    n_chk = 0; n_fail = 0;
    addr = '0; rstrb = 1'b0; sel = 2'd0;
    rnd_en = 1'b1; rnd_bit = 1'b0; rsp = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2 n_sclk_edges = 0;

    // Reset held with random miso and strobes.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rnd_bit = 1'($urandom);
      rstrb = 1'($urandom);
    end
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_cs_n", 32'(cs_m), 32'd1);
      chk("rst_sclk", 32'(sclk_m), 32'd0);
      chk("rst_mosi", 32'(mosi_m), 32'd0);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_rdata", rdata_m, 32'd0);
    end
    chk("rst_no_sclk_edges", 32'(n_sclk_edges), 32'd0);
    sel = 2'd0;
    rstrb = 1'b0;
    rnd_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Basic read, no offset.
    start_read(32'h0000_0104, 32'h1300_0000, 32'h0300_0104, 32'h0000_0013, 128);
    wait_done("basic", -1, -1, 1'b0, 32'h0);

    // Back-to-back: strobe on the falling-busy cycle is ignored.
    cs0 = n_cs_fall;
    start_read(32'h0000_0008, 32'h1122_3344, 32'h0300_0008, 32'h4433_2211, 128);
    wait_done("b2b_1", -1, -1, 1'b1, 32'h0);
    chk("b2b_gap_cs_high", 32'(cs_m), 32'd1);
    chk("b2b_gap_busy_low", 32'(busy_m), 32'd0);
    addr = 32'h0000_000C;
    rsp = 32'hA1B2_C3D4;
    push_exp(32'h0300_000C, 32'hD4C3_B2A1, 128);
    @(negedge clk);
    rstrb = 1'b0;
    chk("b2b_2_cs_low", 32'(cs_m), 32'd0);
    chk("b2b_2_busy", 32'(busy_m), 32'd1);
    chk("b2b_2_rdata_hold", rdata_m, 32'h4433_2211);
    wait_done("b2b_2", -1, -1, 1'b0, 32'h0);
    chk("b2b_cs_falls", 32'(n_cs_fall - cs0), 32'd2);

    // Strobes during busy are ignored.
    cs0 = n_cs_fall;
    dn0 = n_done;
    start_read(32'h0000_0020, 32'h0102_0304, 32'h0300_0020, 32'h0403_0201, 128);
    wait_done("busy_strobe", 10, 50, 1'b0, 32'h00FF_FFFC);
    repeat (20) @(negedge clk);
    chk("busy_strobe_one_start", 32'(n_cs_fall - cs0), 32'd1);
    chk("busy_strobe_one_done", 32'(n_done - dn0), 32'd1);
    chk("busy_strobe_idle", 32'(busy_m), 32'd0);

    // Offset and wrap.
    sel = 2'd1;
    start_read(32'h00F0_0007, 32'h55AA_00FF, 32'h0300_0004, 32'hFF00_AA55, 128);
    wait_done("wrap", -1, -1, 1'b0, 32'h0);
    start_read(32'h0000_0010, 32'h8000_0001, 32'h0310_0010, 32'h0100_0080, 128);
    wait_done("offset", -1, -1, 1'b0, 32'h0);

    // Divider 3: full read, then abort mid-transfer, then read again.
    sel = 2'd2;
    start_read(32'h0000_0200, 32'hEFBE_ADDE, 32'h0310_0200, 32'hDEAD_BEEF, 384);
    wait_done("div3_a", -1, -1, 1'b0, 32'h0);
    chk("div3_a_period", 32'(t_rise1 - t_rise0), 32'd60);
    chk("div3_a_first_rise", 32'(t_rise0 - t_cs_fall), 32'd30);

    start_read(32'h0000_0200, 32'h1234_5678, 32'h0310_0200, 32'h0, 384);
    k = 0;
    while (bitn < 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_bit20", 32'(bitn >= 20), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_m), 32'd1);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_sclk", 32'(sclk_m), 32'd0);
    chk("abort_rdata", rdata_m, 32'd0);
    void'(exp_cmd_q.pop_front());
    void'(exp_dat_q.pop_front());
    void'(exp_lat_q.pop_front());
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    start_read(32'h0000_0200, 32'hEFBE_ADDE, 32'h0310_0200, 32'hDEAD_BEEF, 384);
    wait_done("div3_b", -1, -1, 1'b0, 32'h0);
    chk("div3_b_period", 32'(t_rise1 - t_rise0), 32'd60);
    chk("div3_b_first_rise", 32'(t_rise0 - t_cs_fall), 32'd30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
